// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and helpers for the serial pattern detector
package seq_det_pkg;

    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

    // Width of the fill-level state; fill ranges over 0..n-1.
    function automatic int fill_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear taking priority over increment
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q,
    output logic             sat
);

    logic [CNT_W-1:0] cnt_q;

    assign q   = cnt_q;
    assign sat = &cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (inc && !sat) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised Mealy serial-pattern detector with reloadable pattern
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [N-1:0]     pat_in,
    input  logic             cnt_clr,
    output logic             z,
    output logic             z_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int            FW        = fill_width(N);
    localparam logic [FW-1:0] FILL_FULL = FW'(N - 1);

    logic [N-2:0]  hist_q, hist_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [N-1:0]  pat_q, pat_d;
    logic [N-1:0]  window;
    logic          match_raw;

    // Oldest history bit lands in the MSB, matching the pattern's first-bit-is-MSB order.
    assign window    = {hist_q, x};
    assign match_raw = (fill_q == FILL_FULL) && (window == pat_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PATTERN;
            z_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            z_q    <= z;
        end
    end

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        if (pat_load) begin
            pat_d  = pat_in;
            fill_d = '0;
        end else if (en) begin
            hist_d = window[N-2:0];
            if (z && (overlap == MODE_NONOVL)) begin
                fill_d = '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    always_comb begin
        z = 1'b0;
        if (en && !rst && !pat_load) begin
            z = match_raw;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_match_cnt (
        .clk(clk),
        .rst(rst),
        .inc(z),
        .clr(cnt_clr),
        .q  (match_cnt),
        .sat(cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - randomized and directed self-checking bench for seq_detector_param
module tb_seq_detector_param;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, en, x, overlap, pat_load, cnt_clr;
    logic [N-1:0] pat_in;
    logic         z8, zq8, sat8, z2, zq2, sat2;
    logic [7:0]   cnt8;
    logic [1:0]   cnt2;

    seq_detector_param #(.N(N), .PATTERN(4'b1011), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .z(z8), .z_q(zq8), .match_cnt(cnt8), .cnt_sat(sat8)
    );

    seq_detector_param #(.N(N), .PATTERN(4'b1011), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .z(z2), .z_q(zq2), .match_cnt(cnt2), .cnt_sat(sat2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: the bits consumed since the last restart, the pattern, and plain integer counts.
    bit           q_bits[$];
    logic [N-1:0] m_pat = 4'b1011;
    bit           m_zq  = 1'b0;
    int           m_cnt8 = 0;
    int           m_cnt2 = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_z();
        logic [N-1:0] w;
        if (rst || !en || pat_load || q_bits.size() != N - 1) return 1'b0;
        for (int i = 0; i < N - 1; i++) w[N-1-i] = q_bits[i];
        w[0] = x;
        return (w == m_pat);
    endfunction

    task automatic step(input bit r, input bit e, input bit b, input bit o, input bit l,
                        input logic [N-1:0] p, input bit c, output bit zo);
        bit zexp;
        rst = r; en = e; x = b; overlap = o; pat_load = l; pat_in = p; cnt_clr = c;
        #3;
        zexp = model_z();
        zo   = z8;
        check_eq("z8", z8, zexp);
        check_eq("z2", z2, zexp);
        check_eq("zq8", zq8, m_zq);
        check_eq("zq2", zq2, m_zq);
        check_eq("cnt8", cnt8, m_cnt8);
        check_eq("cnt2", cnt2, m_cnt2);
        check_eq("sat8", sat8, m_cnt8 == 255);
        check_eq("sat2", sat2, m_cnt2 == 3);
        @(posedge clk);
        if (r) begin
            q_bits.delete();
            m_pat  = 4'b1011;
            m_zq   = 1'b0;
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else begin
            m_zq = zexp;
            if (c) begin
                m_cnt8 = 0;
                m_cnt2 = 0;
            end else if (zexp) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (l) begin
                m_pat = p;
                q_bits.delete();
            end else if (e) begin
                if (zexp && !o) begin
                    q_bits.delete();
                end else begin
                    q_bits.push_back(b);
                    if (q_bits.size() > N - 1) void'(q_bits.pop_front());
                end
            end
        end
        #1;
    endtask

    task automatic feed(input logic [15:0] s, input int len, input bit o, output logic [15:0] mask);
        bit zo;
        mask = '0;
        for (int i = len - 1; i >= 0; i--) begin
            step(1'b0, 1'b1, s[i], o, 1'b0, '0, 1'b0, zo);
            mask = {mask[14:0], zo};
        end
    endtask

    task automatic do_reset();
        bit zo;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, zo);
    endtask

    initial begin
        logic [15:0] mask;
        bit          zo;
        rst = 1'b1; en = 1'b0; x = 1'b0; overlap = 1'b0; pat_load = 1'b0; pat_in = '0; cnt_clr = 1'b0;
        @(posedge clk);
        #1;

        do_reset();
        do_reset();
        check_eq("rst_z", z8, 0);
        check_eq("rst_zq", zq8, 0);
        check_eq("rst_cnt", cnt8, 0);
        check_eq("rst_sat", sat8, 0);

        feed(16'b1011011, 7, 1'b1, mask);
        check_eq("ovl_hits", mask, 16'h0009);
        check_eq("ovl_cnt", cnt8, 2);

        do_reset();
        feed(16'b1011011, 7, 1'b0, mask);
        check_eq("novl_hits", mask, 16'h0008);
        check_eq("novl_cnt", cnt8, 1);
        do_reset();
        feed(16'b10111011, 8, 1'b0, mask);
        check_eq("novl_hits2", mask, 16'h0011);

        do_reset();
        feed(16'b10, 2, 1'b1, mask);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, zo);
            check_eq("gap_z", zo, 0);
        end
        feed(16'b11, 2, 1'b1, mask);
        check_eq("gap_hit", mask, 16'h0001);

        do_reset();
        feed(16'b101, 3, 1'b1, mask);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, zo);
        check_eq("load_z", zo, 0);
        feed(16'b0110, 4, 1'b1, mask);
        check_eq("load_hit", mask, 16'h0001);
        feed(16'b101, 3, 1'b1, mask);
        do_reset();
        feed(16'b11011, 5, 1'b1, mask);
        check_eq("rst_mid", mask, 16'h0001);

        do_reset();
        feed(16'b1011011011011011, 16, 1'b1, mask);
        check_eq("sat_cnt2", cnt2, 3);
        check_eq("sat_flag2", sat2, 1);
        check_eq("sat_cnt8", cnt8, 5);
        feed(16'b101, 3, 1'b1, mask);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, zo);
        check_eq("clr_z", zo, 1);
        check_eq("clr_cnt2", cnt2, 0);
        check_eq("clr_cnt8", cnt8, 0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 79) == 0,
                 $urandom_range(0, 99) < 80,
                 1'($urandom),
                 1'($urandom),
                 $urandom_range(0, 39) == 0,
                 N'($urandom),
                 $urandom_range(0, 59) == 0,
                 zo);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
